// File: rtl/pw_sequence_checker.sv
// Password-entry front end: button synchronizer/debouncer, 4-digit sequence FSM
// with entry timeout, relock while open, and lockout after repeated failures.

module pw_sequence_checker_props (
  input logic clkin,
  input logic reset,
  input logic a,
  input logic b,
  input logic c,
  input logic d,
  input logic turnoff,
  input logic unlocked,
  input logic locked
);

  turnoff_single_cycle: assert property (@(posedge clkin) disable iff (reset)
    turnoff |=> !turnoff);

  open_and_lock_exclusive: assert property (@(posedge clkin) disable iff (reset)
    !(unlocked && locked));

  progress_is_thermometer: assert property (@(posedge clkin) disable iff (reset)
    (d |-> c) and (c |-> b) and (b |-> a));

  open_means_all_digits: assert property (@(posedge clkin) disable iff (reset)
    unlocked == d);

  lock_clears_progress: assert property (@(posedge clkin) disable iff (reset)
    locked |-> !a);

endmodule

module pw_sequence_checker #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000,
  parameter int unsigned LOCK_CYCLES     = 500000000,
  parameter int unsigned MAX_FAIL        = 3,
  parameter logic [7:0]  PASSWORD        = 8'b11_10_01_00
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       turnoff,
  output logic       unlocked,
  output logic       locked
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LK_W   = $clog2(LOCK_CYCLES + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [DB_W-1:0]   DB_TERM   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LK_W-1:0]   LK_LAST   = LK_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_TERM = FAIL_W'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_D1   = 3'd1,
    S_D2   = 3'd2,
    S_D3   = 3'd3,
    S_OPEN = 3'd4,
    S_LOCK = 3'd5
  } state_e;

  function automatic logic [3:0] digit_mask(input logic [1:0] idx);
    digit_mask = 4'b0001 << idx;
  endfunction

  logic [3:0]        sync1_q;
  logic [3:0]        sync2_q;
  logic [DB_W-1:0]   db_cnt_q [4];
  logic [DB_W-1:0]   db_cnt_d [4];
  logic [3:0]        deb_q;
  logic [3:0]        deb_d;
  logic [3:0]        deb_prev_q;
  logic [3:0]        rise_q;

  state_e            state_q;
  state_e            state_d;
  logic [FAIL_W-1:0] fail_q;
  logic [FAIL_W-1:0] fail_d;
  logic [FAIL_W-1:0] fail_inc_s;
  logic [TO_W-1:0]   idle_q;
  logic [TO_W-1:0]   idle_d;
  logic [LK_W-1:0]   lock_q;
  logic [LK_W-1:0]   lock_d;
  logic [1:0]        digit_idx_s;
  logic              press_s;
  logic              correct_s;
  logic              abort_s;

  logic a_q, b_q, c_q, d_q, turnoff_q, unlocked_q, locked_q;
  logic a_d, b_d, c_d, d_d, turnoff_d, unlocked_d, locked_d;

  // Two-flop synchronizer per button
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Counter runs only while the synced level disagrees with the accepted one
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      deb_d[i]    = deb_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_TERM) begin
        deb_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Debounced levels and registered rising-edge press events
  always_ff @(posedge clkin) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
      deb_q      <= 4'b0000;
      deb_prev_q <= 4'b0000;
      rise_q     <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      rise_q     <= deb_q & ~deb_prev_q;
    end
  end

  always_comb begin
    case (state_q)
      S_IDLE:  digit_idx_s = PASSWORD[1:0];
      S_D1:    digit_idx_s = PASSWORD[3:2];
      S_D2:    digit_idx_s = PASSWORD[5:4];
      S_D3:    digit_idx_s = PASSWORD[7:6];
      default: digit_idx_s = 2'b00;
    endcase
  end

  // A multi-bit press can never equal a one-hot digit mask, so it is wrong
  assign press_s    = |rise_q;
  assign correct_s  = press_s && (rise_q == digit_mask(digit_idx_s));
  assign fail_inc_s = fail_q + FAIL_W'(1);

  // Next-state, counters and abort decision
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    idle_d  = '0;
    lock_d  = '0;
    abort_s = 1'b0;
    case (state_q)
      S_IDLE, S_D1, S_D2, S_D3: begin
        if (press_s) begin
          if (correct_s) begin
            case (state_q)
              S_IDLE:  state_d = S_D1;
              S_D1:    state_d = S_D2;
              S_D2:    state_d = S_D3;
              S_D3: begin
                state_d = S_OPEN;
                fail_d  = '0;
              end
              default: state_d = S_IDLE;
            endcase
          end else begin
            abort_s = 1'b1;
            if (fail_inc_s == FAIL_TERM) begin
              state_d = S_LOCK;
              fail_d  = '0;
            end else begin
              state_d = S_IDLE;
              fail_d  = fail_inc_s;
            end
          end
        end else if (state_q != S_IDLE) begin
          if (idle_q == TO_LAST) begin
            abort_s = 1'b1;
            state_d = S_IDLE;
          end else begin
            idle_d = idle_q + TO_W'(1);
          end
        end else begin
          idle_d = '0;
        end
      end
      S_OPEN: begin
        if (press_s) begin
          abort_s = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_OPEN;
        end
      end
      S_LOCK: begin
        if (lock_q == LK_LAST) begin
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q + LK_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        fail_d  = '0;
      end
    endcase
  end

  // Outputs decode the next state so they change on the transition edge
  always_comb begin
    a_d        = (state_d == S_D1) || (state_d == S_D2) || (state_d == S_D3) || (state_d == S_OPEN);
    b_d        = (state_d == S_D2) || (state_d == S_D3) || (state_d == S_OPEN);
    c_d        = (state_d == S_D3) || (state_d == S_OPEN);
    d_d        = (state_d == S_OPEN);
    unlocked_d = (state_d == S_OPEN);
    locked_d   = (state_d == S_LOCK);
    turnoff_d  = abort_s && !turnoff_q;
  end

  // State, counters and registered outputs
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fail_q     <= '0;
      idle_q     <= '0;
      lock_q     <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      c_q        <= 1'b0;
      d_q        <= 1'b0;
      turnoff_q  <= 1'b0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      idle_q     <= idle_d;
      lock_q     <= lock_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      turnoff_q  <= turnoff_d;
      unlocked_q <= unlocked_d;
      locked_q   <= locked_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign c        = c_q;
  assign d        = d_q;
  assign turnoff  = turnoff_q;
  assign unlocked = unlocked_q;
  assign locked   = locked_q;

  pw_sequence_checker_props u_props (
    .clkin    (clkin),
    .reset    (reset),
    .a        (a_q),
    .b        (b_q),
    .c        (c_q),
    .d        (d_q),
    .turnoff  (turnoff_q),
    .unlocked (unlocked_q),
    .locked   (locked_q)
  );

endmodule

// File: tb/tb_pw_sequence_checker.sv
// Bench for pw_sequence_checker: directed scenarios plus random presses, compared
// each cycle against a press-level reference model of the password rules.

module tb_pw_sequence_checker;

  localparam int         DEB  = 4;
  localparam int         TO   = 100;
  localparam int         LK   = 50;
  localparam int         MF   = 3;
  localparam logic [7:0] PW   = 8'b11_10_01_00;
  localparam int         MAXC = 40000;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn   = 4'b0000;
  logic       a, b, c, d, turnoff, unlocked, locked;

  int         cyc       = 0;
  bit         rst_seen  = 1'b0;
  logic [3:0] ev [0:MAXC-1];
  int         vectors     = 0;
  int         miscompares = 0;

  pw_sequence_checker #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TO),
    .LOCK_CYCLES     (LK),
    .MAX_FAIL        (MF),
    .PASSWORD        (PW)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .btn      (btn),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .turnoff  (turnoff),
    .unlocked (unlocked),
    .locked   (locked)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: applies each press at the edge where it takes effect
  initial begin : model
    int         m_k;
    int         m_fail;
    int         m_idle;
    int         m_lockcnt;
    bit         m_lock;
    bit         m_toff;
    bit         m_valid;
    bit         abort;
    logic [3:0] p;
    logic [3:0] want;
    logic [7:0] pw_v;
    logic [6:0] exp_v;
    pw_v = PW;
    m_k = 0; m_fail = 0; m_idle = 0; m_lockcnt = 0;
    m_lock = 1'b0; m_toff = 1'b0; m_valid = 1'b0;
    forever begin
      @(negedge clkin);
      if (rst_seen) begin
        m_k = 0; m_fail = 0; m_idle = 0; m_lockcnt = 0;
        m_lock = 1'b0; m_toff = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin
        p     = (cyc < MAXC) ? ev[cyc] : 4'b0000;
        abort = 1'b0;
        if (m_lock) begin
          m_lockcnt++;
          if (m_lockcnt == LK) begin
            m_lock = 1'b0;
            m_k    = 0;
          end
        end else if (m_k == 4) begin
          if (p != 4'b0000) begin
            abort = 1'b1;
            m_k   = 0;
          end
        end else if (p != 4'b0000) begin
          m_idle = 0;
          want   = 4'b0001 << pw_v[2*m_k +: 2];
          if (p == want) begin
            m_k++;
            if (m_k == 4) m_fail = 0;
          end else begin
            abort = 1'b1;
            m_k   = 0;
            m_fail++;
            if (m_fail == MF) begin
              m_lock    = 1'b1;
              m_fail    = 0;
              m_lockcnt = 0;
            end
          end
        end else if (m_k > 0) begin
          m_idle++;
          if (m_idle == TO) begin
            abort  = 1'b1;
            m_k    = 0;
            m_idle = 0;
          end
        end
        m_toff = abort && !m_toff;
      end
      if (m_valid) begin
        exp_v = {m_k >= 1, m_k >= 2, m_k >= 3, m_k == 4, m_toff, m_k == 4, m_lock};
        check_value("outs{a,b,c,d,turnoff,unlocked,locked}",
                    {a, b, c, d, turnoff, unlocked, locked}, exp_v);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clkin);
  endtask

  // A press is a clean event only when held longer than the debounce window
  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    @(negedge clkin);
    btn = mask;
    if (hold > DEB && cyc + DEB + 5 < MAXC) ev[cyc + DEB + 5] = mask;
    repeat (hold) @(negedge clkin);
    btn = 4'b0000;
    repeat (gap - 1) @(negedge clkin);
  endtask

  task automatic enter_password(input int hold, input int gap);
    press(4'b0001, hold, gap);
    press(4'b0010, hold, gap);
    press(4'b0100, hold, gap);
    press(4'b1000, hold, gap);
  endtask

  initial begin : watchdog
    #(MAXC * 10);
    $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
    $fatal(1);
  end

  initial begin : stimulus
    int seq_i;
    int r;
    int bit_i;
    int bit_j;
    for (int i = 0; i < MAXC; i++) ev[i] = 4'b0000;
    reset = 1'b1;
    btn   = 4'b0000;
    repeat (3) @(negedge clkin);
    reset = 1'b0;
    idle(5);

    // correct entry, then relock from OPEN
    enter_password(10, 10);
    idle(10);
    press(4'b0100, 10, 12);

    // bounce is filtered, simultaneous press is wrong
    press(4'b0001, 2, 10);
    press(4'b0011, 10, 12);

    // wrong second digit
    press(4'b0001, 10, 10);
    press(4'b1000, 10, 12);

    // partial entry times out, fail count untouched so entry still unlocks
    press(4'b0001, 10, 10);
    press(4'b0010, 10, 10);
    idle(130);
    enter_password(10, 10);
    idle(10);
    press(4'b0100, 10, 12);

    // lockout after three wrong presses; entry during lock is ignored
    press(4'b1000, 8, 10);
    press(4'b0100, 8, 10);
    press(4'b0010, 8, 10);
    press(4'b0001, 6, 8);
    press(4'b0010, 6, 8);
    press(4'b0100, 6, 8);
    idle(60);
    enter_password(8, 10);
    idle(10);
    press(4'b0001, 10, 12);

    // reset in the middle of an entry
    press(4'b0001, 10, 10);
    press(4'b0010, 10, 14);
    reset = 1'b1;
    @(negedge clkin);
    reset = 1'b0;
    idle(10);

    // randomized presses biased toward the correct sequence
    seq_i = 0;
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        press(4'(4'b0001 << seq_i), $urandom_range(6, 12), $urandom_range(8, 14));
        seq_i = (seq_i + 1) % 4;
      end else if (r <= 7) begin
        press(4'(4'b0001 << $urandom_range(0, 3)), $urandom_range(6, 12), $urandom_range(8, 14));
      end else if (r == 8) begin
        bit_i = $urandom_range(0, 3);
        bit_j = (bit_i + $urandom_range(1, 3)) % 4;
        press(4'(4'b0001 << bit_i) | 4'(4'b0001 << bit_j), $urandom_range(6, 12), $urandom_range(8, 14));
      end else begin
        press(4'(4'b0001 << $urandom_range(0, 3)), $urandom_range(1, 3), $urandom_range(8, 14));
      end
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(90, 130));
        seq_i = 0;
      end
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pw_sequence_checker.md
Name: pw_sequence_checker

Overview:
Password-entry front end for the PW_Detection design. Synchronizes and debounces four push buttons, checks a 4-press password sequence, and drives the per-digit progress levels a, b, c, d and the turnoff pulse consumed by the downstream LED stage. Adds entry timeout, relock on any press while open, and lockout after repeated failures.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
TIMEOUT_CYCLES, 250000000, idle cycles allowed between presses of a partial entry (5 s).
LOCK_CYCLES, 500000000, lockout duration after MAX_FAIL failures (10 s).
MAX_FAIL, 3, consecutive wrong entries that trigger lockout (1..7).
PASSWORD, 8'b11_10_01_00, four 2-bit button indices; digit k is PASSWORD[2k+1:2k], digit 0 is entered first.

Ports:
clkin  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
btn    input  4  raw asynchronous buttons, active high; btn[i] enters index i.
a      output 1  high once digit 0 is accepted.
b      output 1  high once digit 1 is accepted.
c      output 1  high once digit 2 is accepted.
d      output 1  high once digit 3 is accepted (entry complete).
turnoff  output 1  one-cycle pulse: entry aborted or relocked; downstream clears LEDs.
unlocked output 1  high while in OPEN.
locked   output 1  high while in LOCK.

Behaviour:
- One clock, clkin; reset is synchronous and active-high. Reset wins over every other event on the same edge.
- Reset values: a=b=c=d=0, turnoff=0, unlocked=0, locked=0, state=IDLE, fail_cnt=0, all counters 0, debounced levels 0, synchronizers 0.
- Input path: btn passes through a 2-FF synchronizer per bit. Per-bit debounce counter restarts whenever the synced level equals the debounced level. Otherwise it increments; at DEBOUNCE_CYCLES it updates the debounced level and clears.
- A press event is a registered rising edge of a debounced bit.
- Latency: btn held high from edge 0 gives a press event at edge DEBOUNCE_CYCLES+3, and registered outputs change at edge DEBOUNCE_CYCLES+4.
- Press events where more than one bit rises on the same cycle count as a wrong press. Falling edges are ignored.
- States: IDLE, D1, D2, D3, OPEN, LOCK. Dk means k digits have been accepted.
- From IDLE/D1/D2/D3, a correct press advances one state and sets the next progress output (a, b, c, then d). D3 with a correct press goes to OPEN: d=1, unlocked=1, fail_cnt cleared.
- From IDLE/D1/D2/D3, a wrong press does the following:
  - turnoff pulses for 1 cycle; a-d clear on that same edge; fail_cnt increments.
  - If the new fail_cnt equals MAX_FAIL: go to LOCK, locked=1, fail_cnt cleared.
  - Otherwise: go to IDLE.
- Timeout applies in D1/D2/D3 only:
  - The idle counter clears on each press and counts otherwise.
  - At TIMEOUT_CYCLES: turnoff pulse, a-d cleared, go to IDLE, fail_cnt unchanged.
  - A press on the same cycle as the timeout takes priority; the press is evaluated normally.
- OPEN: a-d held high. Any press event causes a turnoff pulse, a-d=0, unlocked=0, go to IDLE; fail_cnt is unchanged. There is no timeout in OPEN.
- LOCK:
  - Press events are ignored, but debouncing continues.
  - After LOCK_CYCLES cycles in LOCK: locked=0, go to IDLE, no turnoff pulse.
- IDLE: a-d=0, no timeout.
- Counter widths are $clog2(param+1). Counters never wrap, because each is cleared at its terminal value.
- turnoff is never high for two consecutive cycles.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, LOCK_CYCLES=50, MAX_FAIL=3, default PASSWORD.
- Correct entry: press btn[0], btn[1], btn[2], btn[3], each held 10 cycles with 10 low between -> a, b, c, d rise in turn, each 8 cycles after its button rises; unlocked=1; turnoff never pulses.
- Bounce and multi-press: a 2-cycle glitch on btn[0] -> no change. Then btn[0] and btn[1] raised together -> single turnoff pulse, fail_cnt=1, state IDLE.
- Wrong digit: correct btn[0], then btn[3] -> a=1 first, then a one-cycle turnoff with a cleared, state IDLE.
- Timeout: enter btn[0], btn[1], then no input -> 100 cycles after the last press event, turnoff pulses and a=b=0. A subsequent correct full entry still unlocks, since fail_cnt was not incremented.
- Lockout: three wrong presses -> locked=1 for exactly 50 cycles. A correct sequence applied during LOCK is ignored; afterwards locked=0 and a correct entry unlocks.
- Relock and reset: in OPEN, press btn[2] -> turnoff pulse, a-d=0, unlocked=0. Assert reset mid-entry (state D2) -> all outputs 0 on the next edge with no turnoff pulse.
